fifo_wr_arbiter: RTL and testbench

//   Round-robin arbiter that shares the single write port of a sync FIFO between
//   N_REQ producers. Grants bursts of up to MAX_BURST words per owner and

---
 rtl/fifo_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of a synchronous FIFO
//   between N_REQ producers. An owner keeps the port for up to MAX_BURST
//   consecutive words, then the search pointer rotates past it. FIFO full
//   stalls any grant without disturbing ownership.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active-high; forces all outputs to 0
//   req          : per-requester write request (held until granted)
//   req_data     : requester i word in bits [i*WIDTH +: WIDTH]
//   fifo_full    : FIFO full flag; blocks all grants
//   gnt          : one-hot; word from requester i accepted this cycle
//   fifo_wr_en   : FIFO write enable (OR of gnt)
//   fifo_wr_data : granted requester's word, 0 when nothing is granted
//   busy         : high while a burst is in progress
//   owner_id     : current or most recent owner index
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   input  logic                     fifo_full,
   output logic [N_REQ-1:0]         gnt,
   output logic                     fifo_wr_en,
   output logic [WIDTH-1:0]         fifo_wr_data,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] owner_id
);

   localparam int          OW = $clog2(N_REQ);
   localparam int          CW = $clog2(MAX_BURST + 1);
   localparam int unsigned NR = N_REQ;

   localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state, state_n;
   logic [OW-1:0]    owner, owner_n;
   logic [OW-1:0]    rr_ptr, rr_ptr_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [CW-1:0]    cnt_inc;

   logic [OW-1:0]    pick;
   logic [OW-1:0]    cand;
   logic             pick_valid;
   logic             grant;
   logic [OW-1:0]    grant_idx;

   logic [WIDTH-1:0] words [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign words[i] = req_data[i*WIDTH +: WIDTH];
   end

   function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
      return (v == LAST_IDX) ? '0 : v + OW'(1);
   endfunction

   // Rotating-priority search: offsets are visited from farthest to nearest
   // so the candidate closest to rr_ptr is the last one written and wins.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      cand       = '0;
      for (int unsigned j = 0; j < NR; j++) begin
         cand = OW'((32'(rr_ptr) + NR - 1 - j) % NR);
         if (req[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_n;
         owner  <= owner_n;
         rr_ptr <= rr_ptr_n;
         cnt    <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      owner_n   = owner;
      rr_ptr_n  = rr_ptr;
      cnt_n     = cnt;
      grant     = 1'b0;
      grant_idx = owner;
      cnt_inc   = cnt + CW'(1);

      unique case (state)
         IDLE: begin
            if (!fifo_full && pick_valid) begin
               grant     = 1'b1;
               grant_idx = pick;
               owner_n   = pick;
               if (MAX_BURST == 1) begin
                  rr_ptr_n = wrap_inc(pick);
               end else begin
                  cnt_n   = CW'(1);
                  state_n = BURST;
               end
            end
         end
         BURST: begin
            // A dropped request releases ownership even while the FIFO is full.
            if (!req[owner]) begin
               state_n  = IDLE;
               rr_ptr_n = wrap_inc(owner);
               cnt_n    = '0;
            end else if (!fifo_full) begin
               grant     = 1'b1;
               grant_idx = owner;
               if (cnt_inc == CNT_MAX) begin
                  state_n  = IDLE;
                  rr_ptr_n = wrap_inc(owner);
                  cnt_n    = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State is already cleared by the async reset, but the IDLE search still
   // sees live requests, so the grant path is gated by rst directly.
   always_comb begin
      gnt          = '0;
      fifo_wr_data = '0;
      if (grant && !rst) begin
         gnt[grant_idx] = 1'b1;
         fifo_wr_data   = words[grant_idx];
      end
   end

   assign fifo_wr_en = grant && !rst;
   assign busy       = (state == BURST) && !rst;
   assign owner_id   = rst ? '0 : owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic           fifo_full = 1'b0;
   logic [N-1:0]   gnt;
   logic           fifo_wr_en;
   logic [W-1:0]   fifo_wr_data;
   logic           busy;
   logic [1:0]     owner_id;

   fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .fifo_full    (fifo_full),
      .gnt          (gnt),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .busy         (busy),
      .owner_id     (owner_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] gnt;
      logic         wr_en;
      logic [W-1:0] data;
      logic         busy;
      logic [1:0]   owner;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] wr_q[$];
   int           n_checks = 0;
   int           n_pass   = 0;

   // Reference model: who owns the port, how many words it has taken so far
   // (0 = nobody bursting), and where the next fair search starts.
   int           m_owner = 0;
   int           m_ptr   = 0;
   int           m_words = 0;
   int           seq [N];
   logic [N-1:0] pend = '0;
   int           last_g = -1;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   function automatic logic [W-1:0] word(input int i);
      return W'((i << 6) | (seq[i] & 63));
   endfunction

   // One cycle of arbitration in plain terms; g = granted requester or -1.
   task automatic model_cycle(input logic [N-1:0] r, input logic f, output int g);
      g = -1;
      if (m_words == 0) begin
         if (!f) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (g < 0 && r[c]) g = c;
            end
         end
         if (g >= 0) begin
            m_owner = g;
            m_words = 1;
            if (m_words == MB) begin
               m_words = 0;
               m_ptr   = (g + 1) % N;
            end
         end
      end else if (!r[m_owner]) begin
         m_words = 0;
         m_ptr   = (m_owner + 1) % N;
      end else if (!f) begin
         g = m_owner;
         m_words++;
         if (m_words == MB) begin
            m_words = 0;
            m_ptr   = (m_owner + 1) % N;
         end
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic f, input logic rs);
      exp_t e;
      int   g;
      @(posedge clk);
      #1;
      rst       = rs;
      req       = r;
      fifo_full = f;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = word(i);
      e = '0;
      g = -1;
      if (rs) begin
         m_owner = 0;
         m_ptr   = 0;
         m_words = 0;
      end else begin
         e.busy  = (m_words > 0);
         e.owner = 2'(m_owner);
         model_cycle(r, f, g);
         if (g >= 0) begin
            e.gnt   = N'(1) << g;
            e.wr_en = 1'b1;
            e.data  = word(g);
            wr_q.push_back(word(g));
            seq[g]++;
         end
      end
      exp_q.push_back(e);
      last_g = g;
   endtask

   exp_t me;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         check("gnt",        int'(gnt),          int'(me.gnt));
         check("fifo_wr_en", int'(fifo_wr_en),   int'(me.wr_en));
         check("wr_data",    int'(fifo_wr_data), int'(me.data));
         check("busy",       int'(busy),         int'(me.busy));
         check("owner_id",   int'(owner_id),     int'(me.owner));
      end
      if (fifo_wr_en) begin
         if (wr_q.size() == 0) check("unexpected_write", 1, 0);
         else check("write_order", int'(fifo_wr_data), int'(wr_q.pop_front()));
      end
   end

   initial begin
      for (int i = 0; i < N; i++) seq[i] = 0;

      step('0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1);

      // lone requester 2 streams 6 words
      for (int c = 0; c < 6; c++) step(4'b0100, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);

      // all requesting, never full
      step('0, 1'b0, 1'b1);
      for (int c = 0; c < 17; c++) step(4'b1111, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);

      // requester 1 stalled by full mid-burst
      step('0, 1'b0, 1'b1);
      for (int c = 0; c < 2; c++) step(4'b0010, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) step(4'b0010, 1'b1, 1'b0);
      for (int c = 0; c < 2; c++) step(4'b0010, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);

      // requester 0 drops mid-burst, requester 3 waiting
      step('0, 1'b0, 1'b1);
      for (int c = 0; c < 2; c++) step(4'b1001, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) step(4'b1000, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);

      // reset during a burst of requester 2
      step('0, 1'b0, 1'b1);
      for (int c = 0; c < 2; c++) step(4'b0100, 1'b0, 1'b0);
      for (int c = 0; c < 2; c++) step(4'b0100, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) step(4'b0110, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);

      // full while idle with rr_ptr moved to 2
      step('0, 1'b0, 1'b1);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b1101, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) step(4'b1111, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) step(4'b1111, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);

      // randomized protocol-compliant traffic
      pend = '0;
      for (int c = 0; c < 3000; c++) begin
         bit f;
         bit rs;
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 99) < 30) pend[i] = 1'b1;
         f  = ($urandom_range(0, 99) < 20);
         rs = ($urandom_range(0, 299) == 0);
         step(pend, f, rs);
         if (last_g >= 0 && $urandom_range(0, 1) == 0) pend[last_g] = 1'b0;
      end

      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("queues_drained", exp_q.size() + wr_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
